// File: rtl/matmul_tile_sequencer.sv
// Chains a 4x4 systolic matmul core across K tiles and owns the start/done handshake.
// Optional watchdog: define MATMUL_SEQ_TIMEOUT_EN to enable the WAIT/FLUSH timeout.
module matmul_tile_sequencer #(
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned KWIDTH   = 4,
    parameter int unsigned TO_WIDTH = 12
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              clear_done,
    input  logic [KWIDTH-1:0] k_tiles,
    input  logic [AWIDTH-1:0] a_base,
    input  logic [AWIDTH-1:0] b_base,
    input  logic [AWIDTH-1:0] a_stride,
    input  logic [AWIDTH-1:0] b_stride,
    output logic              tile_start,
    output logic [AWIDTH-1:0] tile_addr_a,
    output logic [AWIDTH-1:0] tile_addr_b,
    output logic              tile_accumulate,
    input  logic              tile_done,
    output logic              tile_flush,
    input  logic              flush_done,
    output logic [KWIDTH-1:0] tile_idx,
    output logic              busy,
    output logic              done_mat_mul,
    output logic              seq_error
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StNext,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              start_q;
    logic              armed_q;
    logic              start_rise;
    logic              timeout;
    logic [KWIDTH-1:0] kt_q, kt_d;
    logic [KWIDTH-1:0] idx_q, idx_d;
    logic [AWIDTH-1:0] addr_a_q, addr_a_d;
    logic [AWIDTH-1:0] addr_b_q, addr_b_d;
    logic              acc_q, acc_d;
    logic              seq_err_q, seq_err_d;
    logic              tile_start_q, tile_flush_q, busy_q, done_q;

    // armed_q stays low until start is seen low after reset, so a level held
    // through reset cannot masquerade as a rising edge.
    assign start_rise = start & ~start_q & armed_q;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_cnt_q;
    logic [TO_WIDTH-1:0] to_inc;
    logic                to_active;

    assign to_active = (state_q == StWait) || (state_q == StFlush);
    assign to_inc    = to_cnt_q + 1'b1;
    assign timeout   = to_active && (&to_inc);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if ((state_d == StWait || state_d == StFlush) && (state_d != state_q)) begin
            to_cnt_q <= '0;
        end else if (to_active) begin
            to_cnt_q <= to_inc;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        kt_d      = kt_q;
        idx_d     = idx_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        seq_err_d = seq_err_q;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d  = StLaunch;
                    kt_d     = (k_tiles == '0) ? KWIDTH'(1) : k_tiles;
                    idx_d    = '0;
                    addr_a_d = a_base;
                    addr_b_d = b_base;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (tile_done) begin
                    state_d = (idx_q == kt_q - 1'b1) ? StFlush : StNext;
                end else if (timeout) begin
                    state_d   = StDone;
                    seq_err_d = 1'b1;
                end
            end
            StNext: begin
                state_d  = StLaunch;
                idx_d    = idx_q + 1'b1;
                addr_a_d = addr_a_q + a_stride;
                addr_b_d = addr_b_q + b_stride;
            end
            StFlush: begin
                if (flush_done) begin
                    state_d = StDone;
                end else if (timeout) begin
                    state_d   = StDone;
                    seq_err_d = 1'b1;
                end
            end
            StDone: begin
                if (clear_done) begin
                    state_d   = StIdle;
                    seq_err_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        acc_d = acc_q;
        if (state_d == StLaunch) begin
            acc_d = (idx_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            armed_q      <= 1'b0;
            kt_q         <= '0;
            idx_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            acc_q        <= 1'b0;
            seq_err_q    <= 1'b0;
            tile_start_q <= 1'b0;
            tile_flush_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            armed_q      <= armed_q | ~start;
            kt_q         <= kt_d;
            idx_q        <= idx_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            acc_q        <= acc_d;
            seq_err_q    <= seq_err_d;
            tile_start_q <= (state_d == StLaunch);
            tile_flush_q <= (state_d == StFlush) && (state_q != StFlush);
            busy_q       <= (state_d != StIdle) && (state_d != StDone);
            done_q       <= (state_d == StDone);
        end
    end

    assign tile_start      = tile_start_q;
    assign tile_flush      = tile_flush_q;
    assign tile_accumulate = acc_q;
    assign tile_addr_a     = addr_a_q;
    assign tile_addr_b     = addr_b_q;
    assign tile_idx        = idx_q;
    assign busy            = busy_q;
    assign done_mat_mul    = done_q;
    assign seq_error       = seq_err_q;

endmodule
